// File: rtl/dff_checker.sv
// dff_checker: watches the D and Q pins of a flip-flop and checks that each
// enabled cycle's Q equals the D seen on the previous enabled cycle. A run
// consists of NCHECK compares. The run ends in DONE with a pass/fail verdict,
// and err_count records how many compares mismatched.
module dff_checker #(
    parameter int NCHECK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic       d_obs,
    input  logic       q_obs,
    output logic       err,
    output logic [7:0] err_count,
    output logic [7:0] check_count,
    output logic       done,
    output logic       pass,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARM   = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [7:0] NCHECK_W = 8'(NCHECK);

    state_t     state_q, state_d;
    logic       d_prev_q, d_prev_d;
    logic       err_q, err_d;
    logic [7:0] err_count_q, err_count_d;
    logic [7:0] check_count_q, check_count_d;
    logic [7:0] check_count_inc;

    assign check_count_inc = check_count_q + 8'd1;

    // Next-state logic. clr wins over everything else. ARM only captures D so
    // that the first compare in CHECK has a valid previous value. Counters
    // are never touched on the way back to IDLE, so a run survives en gaps.
    always_comb begin
        state_d       = state_q;
        d_prev_d      = d_prev_q;
        err_d         = 1'b0;
        err_count_d   = err_count_q;
        check_count_d = check_count_q;

        if (clr) begin
            state_d       = IDLE;
            d_prev_d      = 1'b0;
            err_count_d   = 8'd0;
            check_count_d = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d  = ARM;
                        d_prev_d = d_obs;
                    end
                end
                ARM: begin
                    if (en) begin
                        state_d  = CHECK;
                        d_prev_d = d_obs;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CHECK: begin
                    if (en) begin
                        d_prev_d      = d_obs;
                        check_count_d = check_count_inc;
                        if (q_obs != d_prev_q) begin
                            err_d = 1'b1;
                            if (err_count_q != 8'hFF) begin
                                err_count_d = err_count_q + 8'd1;
                            end
                        end
                        if (check_count_inc == NCHECK_W) begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and counter registers; reset discards the run immediately,
    // including any pending err pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            d_prev_q      <= 1'b0;
            err_q         <= 1'b0;
            err_count_q   <= 8'd0;
            check_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            d_prev_q      <= d_prev_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
            check_count_q <= check_count_d;
        end
    end

    assign err         = err_q;
    assign err_count   = err_count_q;
    assign check_count = check_count_q;
    assign state       = state_q;
    assign done        = (state_q == DONE);
    assign pass        = (state_q == DONE) && (err_count_q == 8'd0);

endmodule

// File: tb/tb_dff_checker.sv
// Testbench for dff_checker: two instances (NCHECK=4 and NCHECK=255) share
// the same stimulus. A behavioural model tracks each one. Directed scenarios
// are also checked against hand-derived constant tables.
module tb_dff_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic d_obs = 1'b0;
    logic q_obs = 1'b0;

    logic       err_a, done_a, pass_a;
    logic [7:0] err_count_a, check_count_a;
    logic [1:0] state_a;
    logic       err_b, done_b, pass_b;
    logic [7:0] err_count_b, check_count_b;
    logic [1:0] state_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dff_checker #(.NCHECK(4)) dut_a (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .d_obs(d_obs), .q_obs(q_obs),
        .err(err_a), .err_count(err_count_a), .check_count(check_count_a),
        .done(done_a), .pass(pass_a), .state(state_a)
    );

    dff_checker #(.NCHECK(255)) dut_b (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .d_obs(d_obs), .q_obs(q_obs),
        .err(err_b), .err_count(err_count_b), .check_count(check_count_b),
        .done(done_b), .pass(pass_b), .state(state_b)
    );

    // Reference model: phase 0..3 = idle/arm/check/done, plain integer counts.
    int m_phase[2];
    int m_prev[2];
    int m_err[2];
    int m_errc[2];
    int m_chk[2];
    int m_ncheck[2] = '{4, 255};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_prev[i] = 0; m_err[i] = 0; m_errc[i] = 0; m_chk[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input int e, input int c, input int d, input int q);
        m_err[i] = 0;
        if (c != 0) begin
            m_phase[i] = 0; m_prev[i] = 0; m_errc[i] = 0; m_chk[i] = 0;
        end else if (m_phase[i] == 3) begin
            // finished run ignores everything but clr/reset
        end else if (e == 0) begin
            m_phase[i] = 0;
        end else begin
            if (m_phase[i] == 2) begin
                m_chk[i] = m_chk[i] + 1;
                if (q != m_prev[i]) begin
                    m_err[i]  = 1;
                    m_errc[i] = (m_errc[i] + 1 > 255) ? 255 : m_errc[i] + 1;
                end
            end
            m_prev[i] = d;
            if (m_phase[i] == 2 && m_chk[i] == m_ncheck[i]) m_phase[i] = 3;
            else if (m_phase[i] < 2) m_phase[i] = m_phase[i] + 1;
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both DUTs against the model.
    task automatic check_output();
        check_val("a.state", int'(state_a), m_phase[0]);
        check_val("a.err", int'(err_a), m_err[0]);
        check_val("a.err_count", int'(err_count_a), m_errc[0]);
        check_val("a.check_count", int'(check_count_a), m_chk[0]);
        check_val("a.done", int'(done_a), (m_phase[0] == 3) ? 1 : 0);
        check_val("a.pass", int'(pass_a), (m_phase[0] == 3 && m_errc[0] == 0) ? 1 : 0);
        check_val("b.state", int'(state_b), m_phase[1]);
        check_val("b.err", int'(err_b), m_err[1]);
        check_val("b.err_count", int'(err_count_b), m_errc[1]);
        check_val("b.check_count", int'(check_count_b), m_chk[1]);
        check_val("b.done", int'(done_b), (m_phase[1] == 3) ? 1 : 0);
        check_val("b.pass", int'(pass_b), (m_phase[1] == 3 && m_errc[1] == 0) ? 1 : 0);
    endtask

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic apply_stimulus(input int e, input int c, input int d, input int q);
        en = e[0]; clr = c[0]; d_obs = d[0]; q_obs = q[0];
        model_step(0, e, c, d, q);
        model_step(1, e, c, d, q);
        @(posedge clk);
        #1;
        check_output();
    endtask

    typedef struct {
        int en; int clr; int d; int q;
        int st; int chk; int errc; int err; int done; int pass;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int e, input int c, input int d, input int q,
                                input int st, input int chk, input int errc,
                                input int er, input int dn, input int ps);
        vec_t v;
        v.en = e; v.clr = c; v.d = d; v.q = q;
        v.st = st; v.chk = chk; v.errc = errc; v.err = er; v.done = dn; v.pass = ps;
        vecs.push_back(v);
    endfunction

    initial begin
        // good DFF: q follows d one enabled cycle late
        add(0,1,0,0, 0,0,0,0,0,0);
        add(1,0,1,0, 1,0,0,0,0,0);
        add(1,0,0,1, 2,0,0,0,0,0);
        add(1,0,1,0, 2,1,0,0,0,0);
        add(1,0,1,1, 2,2,0,0,0,0);
        add(1,0,0,1, 2,3,0,0,0,0);
        add(1,0,1,0, 3,4,0,0,1,1);
        add(0,0,1,1, 3,4,0,0,1,1);
        // en gap mid-run
        add(0,1,0,0, 0,0,0,0,0,0);
        add(1,0,0,0, 1,0,0,0,0,0);
        add(1,0,0,0, 2,0,0,0,0,0);
        add(1,0,0,0, 2,1,0,0,0,0);
        add(0,0,0,0, 0,1,0,0,0,0);
        add(1,0,0,0, 1,1,0,0,0,0);
        add(1,0,0,0, 2,1,0,0,0,0);
        add(1,0,0,0, 2,2,0,0,0,0);
        add(1,0,0,0, 2,3,0,0,0,0);
        add(1,0,0,0, 3,4,0,0,1,1);
        // clr with en=1 while checking and two errors recorded
        add(0,1,0,0, 0,0,0,0,0,0);
        add(1,0,1,0, 1,0,0,0,0,0);
        add(1,0,1,0, 2,0,0,0,0,0);
        add(1,0,1,0, 2,1,1,1,0,0);
        add(1,0,1,0, 2,2,2,1,0,0);
        add(1,1,1,0, 0,0,0,0,0,0);
        // stuck-at-0 Q, ends in DONE with failure
        add(1,0,1,0, 1,0,0,0,0,0);
        add(1,0,1,0, 2,0,0,0,0,0);
        add(1,0,1,0, 2,1,1,1,0,0);
        add(1,0,1,0, 2,2,2,1,0,0);
        add(1,0,1,0, 2,3,3,1,0,0);
        add(1,0,1,0, 3,4,4,1,1,0);
        add(1,0,1,0, 3,4,4,0,1,0);

        model_reset();
        #12;
        check_output();
        check_val("reset.state", int'(state_a), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].en, vecs[i].clr, vecs[i].d, vecs[i].q);
            check_val($sformatf("vec%0d.state", i), int'(state_a), vecs[i].st);
            check_val($sformatf("vec%0d.check_count", i), int'(check_count_a), vecs[i].chk);
            check_val($sformatf("vec%0d.err_count", i), int'(err_count_a), vecs[i].errc);
            check_val($sformatf("vec%0d.err", i), int'(err_a), vecs[i].err);
            check_val($sformatf("vec%0d.done", i), int'(done_a), vecs[i].done);
            check_val($sformatf("vec%0d.pass", i), int'(pass_a), vecs[i].pass);
        end

        // async reset pulsed between edges while in DONE
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_output();
        check_val("async.done", int'(done_a), 0);
        @(posedge clk);
        #1;
        check_output();
        #3 reset = 1'b0;
        apply_stimulus(1, 0, 0, 0);
        check_val("post_reset.state", int'(state_a), 1);

        // reset while an err pulse is showing leaves no residue
        apply_stimulus(0, 1, 0, 0);
        apply_stimulus(1, 0, 1, 0);
        apply_stimulus(1, 0, 1, 0);
        apply_stimulus(1, 0, 1, 0);
        check_val("pulse.err", int'(err_a), 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_output();
        @(negedge clk);
        reset = 1'b0;

        // saturation: 300 mismatching enabled cycles on the NCHECK=255 unit
        apply_stimulus(0, 1, 0, 0);
        for (int i = 0; i < 300; i++) apply_stimulus(1, 0, 1, 0);
        check_val("sat.err_count", int'(err_count_b), 255);
        check_val("sat.check_count", int'(check_count_b), 255);
        check_val("sat.done", int'(done_b), 1);
        check_val("sat.pass", int'(pass_b), 0);

        // randomized traffic against the model
        apply_stimulus(0, 1, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            apply_stimulus(($urandom_range(0, 9) < 8) ? 1 : 0,
                           ($urandom_range(0, 59) == 0) ? 1 : 0,
                           int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_checker.md
DFF_CHECKER -- requirements
Module: dff_checker

Interface
REQ-001 Parameter NCHECK, default 16, number of compares per run (range 1..255).
REQ-002 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port en  input  1  observe enable; the checker samples only in cycles with en=1.
REQ-005 Port clr  input  1  synchronous clear of run state and counters.
REQ-006 Port d_obs  input  1  observed D input of the flip-flop under check.
REQ-007 Port q_obs  input  1  observed Q output of the flip-flop under check.
REQ-008 Port err  output  1  registered one-cycle pulse per detected mismatch.
REQ-009 Port err_count  output  8  mismatch count for the current run.
REQ-010 Port check_count  output  8  compares completed in the current run.
REQ-011 Port done  output  1  high while in DONE.
REQ-012 Port pass  output  1  high while in DONE with err_count=0.
REQ-013 Port state  output  2  current FSM state; IDLE=00, ARM=01, CHECK=10, DONE=11.

Function
REQ-014 The block SHALL hold an internal register d_prev, loaded with d_obs at every edge where en=1 and the state is IDLE, ARM or CHECK.
REQ-015 In IDLE with en=1, the FSM SHALL go to ARM and load d_prev; with en=0 it SHALL stay in IDLE.
REQ-016 In ARM, the FSM SHALL go to CHECK if en=1; otherwise it SHALL return to IDLE. No compare SHALL occur in ARM.
REQ-017 In CHECK, at each edge with en=1, the block SHALL compare q_obs (sampled at that edge) against d_prev (the d_obs value from the previous enabled edge).
REQ-018 Each such compare SHALL increment check_count by 1.
REQ-019 On a mismatch, err SHALL be 1 for exactly the cycle following the edge; otherwise err SHALL be 0.
REQ-020 On a mismatch, err_count SHALL increment by 1 and saturate at 255.
REQ-021 In CHECK with en=0, the FSM SHALL return to IDLE. Counts SHALL be held, no compare SHALL occur and err SHALL be 0.
REQ-022 When a compare makes check_count equal NCHECK, the FSM SHALL enter DONE on that same edge.
REQ-023 A mismatch on that final compare SHALL be counted and SHALL pulse err.
REQ-024 In DONE, the block SHALL ignore en and d_obs, hold both counters, and assert done=1 and pass=(err_count==0).
REQ-025 It SHALL stay in DONE until clr or reset.
REQ-026 With clr=1 at an edge in any state, the block SHALL go to IDLE and zero err_count, check_count, err and d_prev. clr SHALL have priority over en.
REQ-027 Re-entering ARM from IDLE without clr SHALL NOT clear the counters; a run SHALL accumulate across en gaps.
REQ-028 done and pass SHALL be decoded from registered state and counters only, with no input-to-output combinational path.

Reset
REQ-029 Asserting reset SHALL immediately, independent of clk, force state=IDLE and err, err_count, check_count, d_prev, done and pass to 0.
REQ-030 While reset=1, all outputs SHALL hold at 0.
REQ-031 On release, the first active edge SHALL be evaluated from IDLE.
REQ-032 Reset asserted mid-CHECK or in DONE SHALL discard the run with no residual err pulse.

Verification
REQ-033 Scenario 1, good DFF: NCHECK=4, q_obs = d_obs delayed one cycle, en=1 for 6 cycles from IDLE, d_obs=1,0,1,1,0,... -> state IDLE->ARM->CHECK; check_count reaches 4; done=1, pass=1, err_count=0; err never high.
REQ-034 Scenario 2, stuck-at-0 Q: q_obs=0, d_obs=1 constantly, NCHECK=4 -> err high 4 cycles; err_count=4; done=1, pass=0.
REQ-035 Scenario 3, en gap: en=1 for 3 cycles, en=0 for 1 cycle, then en=1 -> state returns to IDLE, check_count holds 1, run resumes via ARM; after completion check_count=NCHECK.
REQ-036 Scenario 4, clr with en=1 in CHECK with err_count=2 -> next cycle state=IDLE, both counters=0, err=0.
REQ-037 Scenario 5, async reset pulsed between clk edges in DONE -> outputs 0 before the next edge; state=IDLE.
REQ-038 Scenario 6, saturation: NCHECK=255, clr=0 throughout, Q always mismatched over 300 enabled cycles -> err_count=255 when DONE is entered; 255 is held and never wraps.
